// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N byte sources (optional timeout: UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic           tx_wr_en,
    output logic [7:0]     tx_data,
    input  logic           tx_done,
    output logic           busy,
    output logic           err
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] last;
    logic [SW-1:0] sel;
    logic [SW-1:0] pick;
    logic [SW-1:0] cand;
    logic          pick_vld;
    logic          timeout_hit;

    // Search upward from last+1 with a modulo-N wrap (N need not be a power of two).
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = last;
        for (int k = 0; k < N; k++) begin
            cand = (cand == SW'(N - 1)) ? '0 : cand + 1'b1;
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A tx_done seen during START belongs to the previous byte, so START never looks at it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (tx_done || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last    <= SW'(N - 1);
            sel     <= '0;
            gnt     <= '0;
            tx_data <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel     <= pick;
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << pick;
                        tx_data <= req_data[{pick, 3'b000} +: 8];
                    end
                end
                S_DONE: begin
                    last <= sel;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // gnt is one-hot on sel throughout DONE, so it doubles as the ack vector.
    assign ack      = (state == S_DONE) ? gnt : '0;
    assign tx_wr_en = (state == S_START);
    assign busy     = (state != S_IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          to_flag;

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    // to_flag remembers that WAIT exited without tx_done; a simultaneous tx_done wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            if (state == S_START) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            to_flag <= timeout_hit && !tx_done;
        end
    end

    assign err = (state == S_DONE) && to_flag;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           tx_wr_en;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;

    uart_tx_arbiter #(.N(N), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .tx_wr_en (tx_wr_en),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first pending requester after 'last', wrapping modulo N.
    function automatic int rr_pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req     = '0;
        tx_done = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        model_last = N - 1;
    endtask

    // Entered at a negedge with the DUT idle and req already driven; leaves at the following IDLE negedge.
    // mode 0: keep req, 1: drop winner in DONE, 2: drop winner and randomly re-present in DONE.
    task automatic xfer(input int delay, input int mode, output int who);
        int          exp_sel;
        int          lat;
        logic [N-1:0] exp_oh;
        who     = -1;
        exp_sel = rr_pick(req, model_last);
        exp_oh  = '0;
        if (exp_sel >= 0) exp_oh[exp_sel] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tx_wr_en && lat < 4);
        chk("start_latency", 32'(lat), 32'd1);
        if (!tx_wr_en) return;
        for (int i = 0; i < N; i++) if (gnt[i]) who = i;
        chk("start_gnt", 32'(gnt), 32'(exp_oh));
        chk("start_data", 32'(tx_data), 32'(req_data[8*exp_sel +: 8]));
        chk("start_ack", 32'(ack), 32'd0);
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            chk("wait_wr_en", 32'(tx_wr_en), 32'd0);
            chk("wait_ack", 32'(ack), 32'd0);
            chk("wait_gnt", 32'(gnt), 32'(exp_oh));
            if (i == delay) tx_done = 1'b1;
        end
        @(negedge clk);
        tx_done = 1'b0;
        chk("done_ack", 32'(ack), 32'(exp_oh));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_wr_en", 32'(tx_wr_en), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        model_last = exp_sel;
        if (mode >= 1) req[exp_sel] = 1'b0;
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i]              = 1'b1;
                    req_data[8*i +: 8]  = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who;
        int cnt;
        int rr_order [6];
        rr_order = '{0, 1, 3, 0, 1, 3};

        // Reset values with all requesters pending
        rst      = 1'b0;
        tx_done  = 1'b0;
        req      = 4'b1111;
        req_data = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_wr_en", 32'(tx_wr_en), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst        = 1'b1;
        model_last = N - 1;
        xfer(3, 0, who);
        chk("first_grant", 32'(who), 32'd0);

        // Single transfer from requester 2
        do_reset();
        req_data[23:16] = 8'hA5;
        req             = 4'b0100;
        xfer(20, 1, who);
        chk("single_who", 32'(who), 32'd2);
        chk("single_data_const", 32'(req_data[23:16]), 32'hA5);
        repeat (3) begin
            @(negedge clk);
            chk("single_no_rewrite", 32'(tx_wr_en), 32'd0);
        end

        // Round-robin with requester 2 idle
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            xfer(2, 0, who);
            chk("rr_order", 32'(who), 32'(rr_order[i]));
        end

        // Stale done in START, then reset in WAIT
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        chk("stale_start", 32'(tx_wr_en), 32'd1);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("stale_busy", 32'(busy), 32'd1);
        chk("stale_ack", 32'(ack), 32'd0);
        chk("stale_wr_en", 32'(tx_wr_en), 32'd0);
        @(negedge clk);
        chk("stale_hold", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        chk("midrst_no_ack", 32'(ack), 32'd0);
        rst        = 1'b1;
        model_last = N - 1;
        xfer(4, 1, who);
        chk("represent_who", 32'(who), 32'd1);

        // Randomized traffic against the round-robin model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (req == '0) begin
                cnt                  = $urandom_range(0, N - 1);
                req[cnt]             = 1'b1;
                req_data[8*cnt +: 8] = 8'($urandom);
            end
            xfer($urandom_range(1, 6), 2, who);
        end

        // Transmitter never finishes
        do_reset();
        req_data = $urandom;
        req      = 4'b0011;
        cnt      = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_wr_en && cnt < 4);
        chk("to_start", 32'(tx_wr_en), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack == '0 && cnt < 40);
        chk("to_ack_cycle", 32'(cnt), 32'd17);
        chk("to_ack", 32'(ack), 32'b0001);
        chk("to_err", 32'(err), 32'd1);
        model_last = 0;
        req[0]     = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'd0);
        xfer(3, 1, who);
        chk("to_next_who", 32'(who), 32'd1);
`else
        begin
            logic err_seen;
            logic ack_seen;
            err_seen = 1'b0;
            ack_seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                err_seen |= err;
                ack_seen |= |ack;
            end
            chk("stuck_busy", 32'(busy), 32'd1);
            chk("stuck_err", 32'(err_seen), 32'd0);
            chk("stuck_ack", 32'(ack_seen), 32'd0);
        end
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N` independent byte sources (CPU mailbox, status reporter, loopback echo, and so on). It accepts per-requester byte requests and serializes them onto the transmitter's `wr_en`/`in_data` inputs. It tracks completion through `TX_Done` and returns a one-cycle acknowledge to the winning requester. It sits between the requesters and `UART_TX`, alongside `UART_RX` in the UART top level.

## Interface
- `N`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT`, default 4096: cycles to wait for `tx_done` before aborting; used only with `UART_ARB_TIMEOUT_EN`.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req` input, N bits: `req[i]=1` means requester i has a byte pending. It is held until `ack[i]`.
- `req_data` input, 8*N bits: byte of requester i on `req_data[8*i+7:8*i]`, stable while `req[i]` is high.
- `gnt` output, N bits: one-hot, marks the requester currently owning the transmitter.
- `ack` output, N bits: one-cycle pulse to the owner when its byte has completed.
- `tx_wr_en` output, 1 bit: one-cycle start pulse to `UART_TX.wr_en`.
- `tx_data` output, 8 bits: byte to `UART_TX.in_data`, held from START through DONE.
- `tx_done` input, 1 bit: `UART_TX.TX_Done`; stop bit finished.
- `busy` output, 1 bit: high in every state except IDLE.
- `err` output, 1 bit: one-cycle pulse on timeout abort.

## Operation
- The FSM has four states: IDLE, START, WAIT and DONE. All outputs are registered or decoded from registered state.
- **IDLE**
  - If `|req`, select the first asserted `req` index searching upward from `last+1` and wrapping modulo N.
  - Register `tx_data <= req_data[sel]`, `gnt <= onehot(sel)`, and go to START.
  - Otherwise stay in IDLE.
- **START**: `tx_wr_en=1` for exactly this cycle, then go to WAIT. A `tx_done` sampled during START is ignored, because it is stale from the previous byte.
- **WAIT**: when `tx_done=1` is sampled, go to DONE. `tx_data` and `gnt` stay stable.
- **DONE**
  - `ack[sel]=1` for this cycle only, then set `last <= sel`.
  - Clear `gnt` on exit and go to IDLE.
- **Fairness**: `last` advances only in DONE. A requester that holds `req` continuously waits at most N-1 other grants.
- **Requester drops `req` before `ack`**: protocol violation. The transfer still completes and `ack` still pulses, and no abort occurs.
- **`req` changes in the DONE cycle**: not seen until the next IDLE evaluation.
- **Reset values** (asynchronous, while `rst=0`)
  - State IDLE; `gnt=0`, `ack=0`, `tx_wr_en=0`, `tx_data=8'h00`, `busy=0`, `err=0`.
  - `last=N-1`, so the first grant after reset goes to requester 0 when `req[0]` is asserted.
- **Reset mid-transfer**: the FSM returns to IDLE immediately, no `ack` is issued, and the requester must re-present.
- Selection index width is `$clog2(N)`. The round-robin wrap is a modulo-N increment, not a power-of-two wrap.

## Timing
- `req[i]` is sampled high at edge c, which puts the FSM in START during cycle c+1: `tx_wr_en=1`, `tx_data` and `gnt` valid.
- `tx_done` is sampled high at edge k, which puts the FSM in DONE during cycle k+1: `ack` high, `busy` still high.
- At edge k+2 the FSM returns to IDLE. With the next `req` already pending, the next `tx_wr_en` is in cycle k+3.
- Minimum spacing between consecutive `tx_wr_en` pulses is 4 cycles plus the UART frame time.
- `gnt` is high from START through DONE inclusive. `ack` is never high in the same cycle as `tx_wr_en`.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` with no `tx_done`, go to DONE. `ack[sel]` pulses as normal and `err=1` in that same DONE cycle.
  - `last` advances as usual.
  - A `tx_done` in the same cycle the counter hits `TIMEOUT` counts as success, so `err=0`.
- **Undefined**: no counter is built, WAIT waits indefinitely, `err` is tied 0 and `TIMEOUT` is ignored.

## Test plan
- **Reset values**: hold `rst=0` with `req=4'b1111` → all outputs 0 and `tx_data=8'h00`. Release reset → first `gnt=4'b0001` and `tx_data=req_data[7:0]` in the START cycle.
- **Single transfer**: `req[2]=1` with data `8'hA5`, `tx_done` returned 20 cycles after `tx_wr_en` → exactly one `tx_wr_en` pulse, `tx_data=8'hA5`, `gnt=4'b0100`, and `ack[2]` pulses exactly 1 cycle after `tx_done`.
- **Round-robin**: `req=4'b1011` held, and each requester re-asserts after its ack → grant order 0,1,3,0,1,3. Requester 2 is never granted.
- **Stale done and mid-transfer reset**: `tx_done=1` during START → ignored, and the FSM stays in WAIT. Then `rst` is pulsed low in WAIT → `busy=0` immediately and no `ack`.
- **Timeout (macro on, `TIMEOUT=16`)**: `tx_done` never asserted → `ack[sel]` and `err` both pulse 17 cycles after START and the next requester is granted. The same bench with the macro off shows `busy` stuck high and `err=0`.
